// File: rtl/lane_align_buffer.sv
// lane_align_buffer
//   Multi-lane valid/ready buffer. Each lane has its own DEPTH-entry FIFO.
//   In independent mode (align_q=0) every lane drains on its own; in aligned
//   mode (align_q=1) lanes present data and pop only in lockstep, once every
//   lane holds at least one entry. The mode input is registered into align_q,
//   so a mode change takes effect one cycle after it is requested.
//
// Optional build macro: LANE_ALIGN_STATS_EN
//   When defined, adds the stall_cnt output. stall_cnt is a saturating count
//   of aligned-mode cycles where some lane holds data but not every lane does.
//
// Ports
//   clk        sole clock, posedge
//   reset      synchronous, active-high
//   align      mode request: 0 independent, 1 aligned
//   in_valid   per-lane push request
//   in_ready   per-lane space available (forced 0 while reset=1)
//   in_data    lane i at [i*WIDTH +: WIDTH]
//   out_valid  per-lane data available under the current mode (0 while reset=1)
//   out_ready  per-lane consumer accept
//   out_data   head entry of each lane
//   count      per-lane occupancy 0..DEPTH, lane i at [i*CW +: CW]
//   stall_cnt  (LANE_ALIGN_STATS_EN only) 16-bit saturating skew-stall count

module lane_align_buffer #(
  parameter  int LANES = 2,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   align,
  input  logic [LANES-1:0]       in_valid,
  output logic [LANES-1:0]       in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES*CW-1:0]    count
`ifdef LANE_ALIGN_STATS_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic             align_q;
  logic [LANES-1:0] nz;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop;
  logic             all_ne;

  assign all_ne = &nz;

  // Mode register: all output logic looks at align_q, never at align directly.
  always_ff @(posedge clk) begin
    if (reset) align_q <= 1'b0;
    else       align_q <= align;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    assign nz[i]       = (cnt != '0);
    // Readiness depends only on occupancy: a full lane refuses a push even if
    // it pops in the same cycle, keeping out_ready off the in_ready path.
    assign in_ready[i] = ~reset & (cnt != CW'(DEPTH));
    assign out_valid[i] = ~reset & (align_q ? all_ne : nz[i]);
    assign push[i]     = in_valid[i] & in_ready[i];
    // In aligned mode a lane pops only when every consumer accepts, so a
    // partial out_ready never splits a lane-coherent word.
    assign pop[i]      = out_valid[i] & (align_q ? (&out_ready) : out_ready[i]);

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[i])  rd_ptr <= rd_ptr + PW'(1);
        cnt <= cnt + CW'(push[i]) - CW'(pop[i]);
      end
    end

    // Storage carries data only and is never reset.
    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= in_data[i*WIDTH +: WIDTH];
    end

    assign out_data[i*WIDTH +: WIDTH] = mem[rd_ptr];
    assign count[i*CW +: CW]          = cnt;
  end

`ifdef LANE_ALIGN_STATS_EN
  logic any_ne;
  logic skew_stall;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign any_ne     = |nz;
  assign skew_stall = align_q & any_ne & ~all_ne;

  always_ff @(posedge clk) begin
    if (reset)           stall_cnt <= '0;
    else if (skew_stall) stall_cnt <= sat_inc16(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_lane_align_buffer.sv
// Directed testbench for lane_align_buffer with LANES=2, WIDTH=8, DEPTH=4.
module tb_lane_align_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        align;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [15:0] in_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [15:0] out_data;
  logic [5:0]  count;
`ifdef LANE_ALIGN_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  lane_align_buffer #(.LANES(2), .WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .align     (align),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
`ifdef LANE_ALIGN_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply the currently driven inputs at the next rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] seq_b [4] = '{8'h51, 8'h52, 8'h53, 8'h54};
  logic [7:0] seq_c [3] = '{8'h53, 8'h54, 8'h55};

  initial begin
    reset = 1'b1; align = 1'b0; in_valid = 2'b00; in_data = 16'h0; out_ready = 2'b00;
    #1;
    check("rst_in_ready_during", 32'(in_ready), 32'h0);
    check("rst_out_valid_during", 32'(out_valid), 32'h0);
    step();
    step();
    check("rst_in_ready_held", 32'(in_ready), 32'h0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'h3);
    check("idle_out_valid", 32'(out_valid), 32'h0);
    check("idle_count", 32'(count), 32'h0);
`ifdef LANE_ALIGN_STATS_EN
    check("idle_stall", 32'(stall_cnt), 32'h0);
`endif

    // Independent mode: fill lane0 while the consumer stalls.
    for (int k = 0; k < 4; k++) begin
      in_valid = 2'b01; in_data = {8'h00, seq_a[k]};
      step();
    end
    in_valid = 2'b00;
    #1;
    check("ind_full_count0", 32'(count[2:0]), 32'd4);
    check("ind_full_count1", 32'(count[5:3]), 32'd0);
    check("ind_full_in_ready", 32'(in_ready), 32'h2);
    check("ind_full_out_valid", 32'(out_valid), 32'h1);
    out_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      check("ind_drain_data", 32'(out_data[7:0]), 32'(seq_a[k]));
      check("ind_drain_valid", 32'(out_valid), 32'h1);
      step();
    end
    check("ind_drain_count0", 32'(count[2:0]), 32'd0);
    check("ind_drain_out_valid", 32'(out_valid), 32'h0);
    out_ready = 2'b00;

    // Aligned mode: lane0 alone does not present data.
    align = 1'b1;
    step();
    in_valid = 2'b01; in_data = 16'h00A1;
    step();
    in_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      check("aln_skew_out_valid", 32'(out_valid), 32'h0);
      step();
    end
`ifdef LANE_ALIGN_STATS_EN
    check("aln_stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    in_valid = 2'b10; in_data = 16'hB100;
    step();
    in_valid = 2'b00;
    check("aln_out_valid", 32'(out_valid), 32'h3);
    check("aln_out_data", 32'(out_data), 32'hB1A1);
    check("aln_counts", 32'(count), {26'd0, 3'd1, 3'd1});

    // Partial out_ready must not pop anything.
    out_ready = 2'b01;
    step();
    check("aln_partial_counts", 32'(count), {26'd0, 3'd1, 3'd1});
    check("aln_partial_valid", 32'(out_valid), 32'h3);
    out_ready = 2'b11;
    step();
    check("aln_pop_counts", 32'(count), 32'h0);
    check("aln_pop_valid", 32'(out_valid), 32'h0);
    out_ready = 2'b00;

    // Full lane with simultaneous push and pop, including pointer wrap.
    align = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      in_valid = 2'b01; in_data = {8'h00, seq_b[k]};
      step();
    end
    check("full_count0", 32'(count[2:0]), 32'd4);
    in_data = 16'h0055; out_ready = 2'b01;
    #1;
    check("full_in_ready0", 32'(in_ready[0]), 32'h0);
    check("full_head", 32'(out_data[7:0]), 32'h51);
    step();
    check("full_refused_count0", 32'(count[2:0]), 32'd3);
    check("full_in_ready_again", 32'(in_ready[0]), 32'h1);
    check("pp_head", 32'(out_data[7:0]), 32'h52);
    step();
    in_valid = 2'b00;
    check("pp_count0", 32'(count[2:0]), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check("wrap_data", 32'(out_data[7:0]), 32'(seq_c[k]));
      step();
    end
    check("wrap_count0", 32'(count[2:0]), 32'd0);
    out_ready = 2'b00;

    // Mode switch with lane0=2, lane1=0.
    for (int k = 0; k < 2; k++) begin
      in_valid = 2'b01; in_data = 16'h0061 + 16'(k);
      step();
    end
    in_valid = 2'b00;
    check("sw_pre_valid", 32'(out_valid), 32'h1);
    align = 1'b1;
    #1;
    check("sw_one_more_valid", 32'(out_valid), 32'h1);
    step();
    check("sw_after_valid", 32'(out_valid), 32'h0);
    check("sw_count0_kept", 32'(count[2:0]), 32'd2);
    for (int k = 0; k < 3; k++) begin
      in_valid = 2'b10; in_data = 16'h7000 + 16'(k << 8);
      step();
    end
    in_valid = 2'b00;
    check("pre_rst_counts", 32'(count), {26'd0, 3'd3, 3'd2});
    check("pre_rst_valid", 32'(out_valid), 32'h3);

    // Reset mid-operation: pending entries dropped, no push/pop at that edge.
    reset = 1'b1; in_valid = 2'b11; out_ready = 2'b11;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    step();
    check("mid_rst_counts", 32'(count), 32'h0);
    reset = 1'b0; in_valid = 2'b00; out_ready = 2'b00;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h3);
    check("post_rst_out_valid", 32'(out_valid), 32'h0);
`ifdef LANE_ALIGN_STATS_EN
    check("post_rst_stall", 32'(stall_cnt), 32'h0);
`endif
    step();
    check("post_rst_counts", 32'(count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
